// File: rtl/pio_panel_in_debounced.sv
// Front-panel input PIO: 2-FF synchroniser, per-bit debounce, sticky edge
// capture with W1C clear, and a maskable level interrupt on an Avalon-MM slave.
module pio_panel_in_debounced #(
    parameter int              WIDTH           = 8,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL    = {WIDTH{1'b1}},
    parameter int              EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] ec_clr;
    logic [WIDTH-1:0] wdata_w;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata_w      = writedata[WIDTH-1:0];
    assign unused_wdata = &{1'b0, writedata};

    // in_port is sampled only here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // A bit is accepted only after sync2 differs for DEBOUNCE_CYCLES straight clocks
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        logic [CNT_W-1:0] cnt_q;
        logic             db_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                db_q  <= RESET_LEVEL[i];
            end else if (sync2[i] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                db_q  <= sync2[i];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign debounced[i] = db_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= RESET_LEVEL;
        end else begin
            prev <= debounced;
        end
    end

    always_comb begin
        edge_vec = '0;
        if (EDGE_TYPE == 0) begin
            edge_vec = ~prev & debounced;
        end else if (EDGE_TYPE == 1) begin
            edge_vec = prev & ~debounced;
        end else begin
            edge_vec = prev ^ debounced;
        end
    end

    assign ec_clr = (wr_en && address == 2'd3) ? wdata_w : '0;

    // Edge set is OR-ed after the clear so a coincident edge is never lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irqmask <= wdata_w;
            end
            edgecapture <= (edgecapture & ~ec_clr) | edge_vec;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(debounced);
            2'd1:    rd_mux = 32'(sync2);
            2'd2:    rd_mux = 32'(irqmask);
            default: rd_mux = 32'(edgecapture);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_panel_in_debounced.sv
// Directed bench for pio_panel_in_debounced: register table plus hand-timed
// sequences for debounce latency, glitch rejection, W1C set-wins and reset.
module tb_pio_panel_in_debounced;

    localparam int WIDTH           = 8;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int NVEC            = 16;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [1:0]       address    = 2'd0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = 32'h0;
    logic [WIDTH-1:0] in_port    = 8'hFF;
    logic [31:0]      readdata;
    logic             irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    pio_panel_in_debounced #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (8'hFF),
        .EDGE_TYPE      (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus(input logic [1:0] a, input logic cs, input logic wr, input logic [31:0] d);
        address    = a;
        chipselect = cs;
        write_n    = ~wr;
        writedata  = d;
    endtask

    task automatic rd(input logic [1:0] a);
        bus(a, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        // Each row: bus cycle applied for one clock; exp_rd is the addressed
        // register as it stood before that clock edge.
        vecs[0]  = '{2'd0, 1'b1, 1'b0, 32'h0,        32'hFF, 1'b0};
        vecs[1]  = '{2'd1, 1'b1, 1'b0, 32'h0,        32'hFF, 1'b0};
        vecs[2]  = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h00, 1'b0};
        vecs[3]  = '{2'd3, 1'b1, 1'b0, 32'h0,        32'h00, 1'b0};
        vecs[4]  = '{2'd0, 1'b1, 1'b1, 32'h0,        32'hFF, 1'b0};
        vecs[5]  = '{2'd1, 1'b1, 1'b1, 32'h0,        32'hFF, 1'b0};
        vecs[6]  = '{2'd2, 1'b1, 1'b1, 32'hFFFFFF5A, 32'h00, 1'b0};
        vecs[7]  = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h5A, 1'b0};
        vecs[8]  = '{2'd0, 1'b1, 1'b0, 32'h0,        32'hFF, 1'b0};
        vecs[9]  = '{2'd1, 1'b1, 1'b0, 32'h0,        32'hFF, 1'b0};
        vecs[10] = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h5A, 1'b0};
        vecs[11] = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h5A, 1'b0};
        vecs[12] = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h5A, 1'b0};
        vecs[13] = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h00, 1'b0};
        vecs[14] = '{2'd3, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00, 1'b0};
        vecs[15] = '{2'd3, 1'b1, 1'b0, 32'h0,        32'h00, 1'b0};

        // Reset
        repeat (2) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check_irq("rst_irq", 1'b0);
        reset_n = 1'b1;

        // Register map, ignored writes, chipselect gating, upper bits zero
        for (int i = 0; i < NVEC; i++) begin
            bus(vecs[i].addr, vecs[i].cs, vecs[i].wr, vecs[i].wdata);
            tick();
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            check_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end

        // readdata holds until the next edge after an address change
        rd(2'd0);
        #1;
        check("rd_latency_hold", readdata, 32'h0);
        tick();
        check("rd_latency_new", readdata, 32'hFF);

        // Bit0 fall: raw then debounced latency, capture, mask enable
        rd(2'd1);
        in_port = 8'hFE;
        tick(); tick();
        check("raw_not_yet", readdata, 32'hFF);
        tick();
        check("raw_bit0", readdata, 32'hFE);
        rd(2'd0);
        tick(); tick(); tick();
        check("data_not_yet", readdata, 32'hFF);
        tick();
        check("data_bit0", readdata, 32'hFE);
        check_irq("irq_masked", 1'b0);
        rd(2'd3);
        tick();
        check("ec_bit0", readdata, 32'h01);
        bus(2'd2, 1'b1, 1'b1, 32'h01);
        check_irq("irq_before_mask", 1'b0);
        tick();
        check_irq("irq_after_mask", 1'b1);
        bus(2'd2, 1'b1, 1'b1, 32'h08);
        tick();
        check_irq("irq_mask_bit3_only", 1'b0);

        // Bit3 glitch then sustained low: exact cycle of acceptance and capture
        rd(2'd0);
        in_port = 8'hF6;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) in_port = 8'hFE;
            if (k == 5) in_port = 8'hF6;
            tick();
            check($sformatf("glitch_rd_k%0d", k), readdata, (k <= 10) ? 32'hFE : 32'hF6);
            check_irq($sformatf("glitch_irq_k%0d", k), k >= 11);
        end

        // W1C: clearing bit0 leaves bit3
        rd(2'd3);
        tick();
        check("ec_pre_w1c", readdata, 32'h09);
        bus(2'd3, 1'b1, 1'b1, 32'h01);
        tick();
        check("w1c_rd_old", readdata, 32'h09);
        check_irq("w1c_irq_bit3", 1'b1);
        rd(2'd3);
        tick();
        check("w1c_bit0", readdata, 32'h08);
        bus(2'd3, 1'b1, 1'b1, 32'h08);
        tick();
        check_irq("w1c_irq_clear", 1'b0);
        rd(2'd3);
        tick();
        check("w1c_bit3", readdata, 32'h00);

        // Release bit3: rising edge must not be captured
        in_port = 8'hFE;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("rise_nocap_k%0d", k), readdata, 32'h00);
        end
        rd(2'd0);
        tick();
        check("rise_data", readdata, 32'hFE);

        // New bit3 fall coincident with a W1C of bit3: set wins
        rd(2'd3);
        in_port = 8'hF6;
        repeat (6) tick();
        bus(2'd3, 1'b1, 1'b1, 32'h08);
        tick();
        check("setwins_rd_old", readdata, 32'h00);
        check_irq("setwins_irq", 1'b1);
        rd(2'd3);
        tick();
        check("setwins_ec", readdata, 32'h08);

        // Async reset clears everything, including a live irq
        rd(2'd0);
        reset_n = 1'b0;
        #1;
        check_irq("rst2_irq", 1'b0);
        check("rst2_readdata", readdata, 32'h0);
        in_port = 8'hFF;
        tick();
        reset_n = 1'b1;

        // Reset at debounce count 2: full re-debounce after release
        in_port = 8'hFE;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("rst3_readdata", readdata, 32'h0);
        check_irq("rst3_irq", 1'b0);
        tick(); tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("redb_rd_k%0d", k), readdata, (k <= 6) ? 32'hFF : 32'hFE);
            check_irq($sformatf("redb_irq_k%0d", k), 1'b0);
        end
        rd(2'd3);
        tick();
        check("redb_ec", readdata, 32'h01);
        rd(2'd2);
        tick();
        check("redb_mask", readdata, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pio_panel_in_debounced.md
Name: pio_panel_in_debounced

Overview:
Avalon-MM slave input PIO for the front-panel push-button/switch bank. It is the read-side counterpart of the LED panel output PIO.
- Synchronises and debounces each panel input bit.
- Captures selected edges into a sticky register.
- Raises a maskable interrupt to the Nios processor.
- Sits on the same peripheral bus segment as the other MebX PIOs.

Parameters:
WIDTH, 8, number of panel input bits (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable clocks required before a bit change is accepted (>=1; 1 ms at 50 MHz)
RESET_LEVEL, 8'hFF, reset value of sync and debounced registers (buttons are active-low, so idle is high)
EDGE_TYPE, 1, edges captured: 0 rising, 1 falling, 2 any

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  2  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  raw asynchronous panel inputs
readdata  out  32  registered read data, read latency 1
irq  out  1  level interrupt, active-high

Behaviour:
- Reset is decided: reset_n, asynchronous, active-low; clock clk. All state is cleared asynchronously.
- Reset values:
  - sync1, sync2, debounced = RESET_LEVEL.
  - Debounce counters = 0.
  - irqmask = 0.
  - edgecapture = 0.
  - readdata = 0.
  - irq = 0.
- Synchroniser: 2-FF chain per bit, in_port -> sync1 -> sync2. No other logic samples in_port.
- Debounce, per bit, with a counter of width clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == debounced, the counter clears to 0.
  - Else, if the counter == DEBOUNCE_CYCLES-1, debounced <= sync2 and the counter clears.
  - Else the counter increments.
  - The net effect: sync2 must differ for DEBOUNCE_CYCLES consecutive clocks. A single matching cycle restarts the count.
  - Counter never wraps.
- Latency: in_port step held stable -> debounced changes 2+DEBOUNCE_CYCLES clocks later.
- Edge detect, on debounced vs its value from the previous clock:
  - rise = ~prev & cur.
  - fall = prev & ~cur.
  - Edge vector selected by EDGE_TYPE.
  - prev resets to RESET_LEVEL, so reset produces no edge.
- edgecapture[i], sticky:
  - Set on edge[i]; visible one clock after debounced changes.
  - Cleared by a write to address 3 with writedata[i]=1; writedata[i]=0 leaves the bit unchanged.
  - Same-cycle edge and clear: set wins, so no edge is lost.
- irq = |(edgecapture & irqmask[WIDTH-1:0]), driven combinationally from registers only. It asserts in the same clock edgecapture is set, or the clock after an irqmask write that enables a pending bit.
- Register map (word address):
  - 0 data: RO, debounced; writes ignored.
  - 1 raw: RO, sync2 (for diagnostics); writes ignored.
  - 2 irqmask: RW, WIDTH bits.
  - 3 edgecapture: R / W1C.
- Write qualification: write when chipselect && !write_n.
- readdata:
  - Registered every clock from the mux on the current address, zero-extended to 32 bits; upper bits always 0.
  - The value sampled 1 clock after the address is presented reflects register state at the address cycle.
  - Reads have no side effects; edgecapture is not clear-on-read.
- Reset mid-debounce: the counter is discarded and debounced returns to RESET_LEVEL. An input still asserted after release must be re-debounced in full.
- WIDTH<32: writedata bits >= WIDTH are ignored.

Test Plan:
Bench configuration: WIDTH=8, DEBOUNCE_CYCLES=4, RESET_LEVEL=8'hFF, EDGE_TYPE=1.
1. Reset, then read every address -> data=0xFF, raw=0xFF, irqmask=0, edgecapture=0, irq=0; readdata valid exactly 1 clock after address.
2. Drive in_port[0]=0 and hold -> raw bit0=0 after 2 clks; data bit0=0 after 6 clks; edgecapture=0x01 at clk 7; irq stays 0 (mask 0). Then write irqmask=0x01 -> irq=1 the next clk.
3. Glitch: in_port[3] low for 3 clks, high 1 clk, low 3 clks -> data bit3 stays 1, edgecapture unchanged. Then hold low 4 clks past sync -> data bit3=0, edgecapture bit3 set.
4. W1C: edgecapture=0x09, write 0x01 to addr 3 -> edgecapture=0x08. Write 0x08 in the same clk a new fall on bit3 is detected -> bit3 remains 1 (set wins). Release (rising edge) -> no capture with EDGE_TYPE=1.
5. Reset mid-operation: assert reset_n=0 at debounce count 2 with in_port=0xFE -> all registers return to reset values. After release, data bit0 falls only after a full 2+4 clks.
6. Writes to addr 0/1 and writedata[31:8]=all-ones to addr 2 -> data/raw unchanged; irqmask reads back only [7:0], and readdata[31:8]=0.
